mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 42 ++++
 tb/tb_mem_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data memory plus MEM/WB pipeline register
module mem_stage #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  control_wb,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [4:0]  write_register,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [1:0]  control_wb_out_1,
  output logic [31:0] read_data_out_1,
  output logic [31:0] mem_alu_result_1,
  output logic [31:0] mem_write_reg_1
);
  logic [31:0] mem [MEM_DEPTH] = '{default: '0};
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] rd;
  logic unused_addr;
  assign idx = address[ADDR_BITS-1:0];
  assign unused_addr = ^address[31:ADDR_BITS];
  always_comb rd = MemRead ? mem[idx] : '0;
  // Reset gates writes but never clears the array, so stored data survives it
  always_ff @(posedge CLK)
    if (!RST && MemWrite) mem[idx] <= writeData;
  always_ff @(posedge CLK) begin
    if (RST) begin
      control_wb_out_1 <= '0;
      read_data_out_1  <= '0;
      mem_alu_result_1 <= '0;
      mem_write_reg_1  <= '0;
    end else begin
      control_wb_out_1 <= control_wb;
      read_data_out_1  <= rd;
      mem_alu_result_1 <= address;
      mem_write_reg_1  <= {27'b0, write_register};
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        CLK = 0;
  logic        RST = 1;
  logic [1:0]  control_wb = '0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [4:0]  write_register = '0;
  logic        MemRead = 0;
  logic        MemWrite = 0;
  logic [1:0]  control_wb_out_1;
  logic [31:0] read_data_out_1;
  logic [31:0] mem_alu_result_1;
  logic [31:0] mem_write_reg_1;
  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .control_wb(control_wb), .address(address),
    .writeData(writeData), .write_register(write_register),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .control_wb_out_1(control_wb_out_1), .read_data_out_1(read_data_out_1),
    .mem_alu_result_1(mem_alu_result_1), .mem_write_reg_1(mem_write_reg_1)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd_en, input logic wr_en, input logic [4:0] wr, input logic [1:0] cw);
    RST = r; address = a; writeData = wd; MemRead = rd_en; MemWrite = wr_en;
    write_register = wr; control_wb = cw;
  endtask

  initial begin
    drive(1, 32'd10, 32'd1, 1, 1, 5'd7, 2'b11);
    tick;
    chk("rst_cwb", {30'b0, control_wb_out_1}, 32'd0);
    chk("rst_rd", read_data_out_1, 32'd0);
    chk("rst_alu", mem_alu_result_1, 32'd0);
    chk("rst_wreg", mem_write_reg_1, 32'd0);
    drive(0, 32'd10, 32'd7, 0, 1, 5'd24, 2'b10);
    tick;
    chk("st10_wreg", mem_write_reg_1, 32'd24);
    chk("st10_cwb", {30'b0, control_wb_out_1}, 32'd2);
    chk("st10_alu", mem_alu_result_1, 32'd10);
    chk("st10_rd_off", read_data_out_1, 32'd0);
    drive(0, 32'd10, 32'd0, 1, 0, 5'd2, 2'b01);
    tick;
    chk("ld10_rd", read_data_out_1, 32'd7);
    chk("ld10_alu", mem_alu_result_1, 32'd10);
    chk("ld10_wreg", mem_write_reg_1, 32'd2);
    chk("ld10_cwb", {30'b0, control_wb_out_1}, 32'd1);
    drive(0, 32'd20, 32'd3, 0, 1, 5'd0, 2'b00);
    tick;
    drive(0, 32'd20, 32'd0, 1, 0, 5'd0, 2'b00);
    tick;
    chk("ld20_rd", read_data_out_1, 32'd3);
    drive(0, 32'd10, 32'd0, 1, 0, 5'd0, 2'b00);
    tick;
    chk("reld10_rd", read_data_out_1, 32'd7);
    drive(0, 32'd10, 32'd9, 1, 1, 5'd0, 2'b00);
    tick;
    chk("rw_old_rd", read_data_out_1, 32'd7);
    drive(0, 32'd10, 32'd0, 1, 0, 5'd0, 2'b00);
    tick;
    chk("rw_new_rd", read_data_out_1, 32'd9);
    drive(1, 32'd10, 32'd5, 1, 1, 5'd31, 2'b11);
    tick;
    chk("rst2_cwb", {30'b0, control_wb_out_1}, 32'd0);
    chk("rst2_rd", read_data_out_1, 32'd0);
    chk("rst2_alu", mem_alu_result_1, 32'd0);
    chk("rst2_wreg", mem_write_reg_1, 32'd0);
    drive(0, 32'd10, 32'd0, 1, 0, 5'd31, 2'b11);
    tick;
    chk("post_rst_rd", read_data_out_1, 32'd9);
    chk("wreg31", mem_write_reg_1, 32'd31);
    drive(0, 32'd266, 32'd0, 1, 0, 5'd0, 2'b00);
    tick;
    chk("alias_rd", read_data_out_1, 32'd9);
    chk("alias_alu", mem_alu_result_1, 32'd266);
    drive(0, 32'd276, 32'hDEADBEEF, 0, 1, 5'd0, 2'b00);
    tick;
    drive(0, 32'd20, 32'd0, 1, 0, 5'd0, 2'b00);
    tick;
    chk("alias_wr_rd", read_data_out_1, 32'hDEADBEEF);
    drive(0, 32'd10, 32'd0, 0, 0, 5'd0, 2'b00);
    tick;
    chk("noread_rd", read_data_out_1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
